// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the decode-stage hazard scoreboard: in-flight writeback entry and sizing helpers.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t wbaddr;
        logic      rf_wen;
        logic      is_load;
        logic      is_csr;
    } hazard_entry_t;

    // Bypass select needs one code per stage plus "regfile".
    function automatic int unsigned sel_width(input int unsigned nstages);
        return $clog2(nstages + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decoder <-> scoreboard bundle: decode-stage operand/destination info in, stall and bypass selects out.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned SELW = 2
);
    typedef logic [SELW-1:0] bypass_sel_t;

    logic        dec_valid;
    reg_addr_t   dec_rs1_addr;
    reg_addr_t   dec_rs2_addr;
    logic        dec_rs1_oen;
    logic        dec_rs2_oen;
    reg_addr_t   dec_wb_addr;
    logic        dec_rf_wen;
    logic        dec_is_load;
    logic        dec_is_csr;
    logic        dec_kill;
    logic        cmiss_stall;
    logic        dec_stall;
    bypass_sel_t rs1_byp_sel;
    bypass_sel_t rs2_byp_sel;
    logic        pipe_busy;

    modport master (
        output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_oen, dec_rs2_oen,
               dec_wb_addr, dec_rf_wen, dec_is_load, dec_is_csr, dec_kill, cmiss_stall,
        input  dec_stall, rs1_byp_sel, rs2_byp_sel, pipe_busy
    );

    modport slave (
        input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_oen, dec_rs2_oen,
               dec_wb_addr, dec_rf_wen, dec_is_load, dec_is_csr, dec_kill, cmiss_stall,
        output dec_stall, rs1_byp_sel, rs2_byp_sel, pipe_busy
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Per-operand hazard check: finds the youngest in-flight writer of src and decides forward vs stall.
module hazard_scoreboard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned LOAD_READY = 1,
    parameter bit          BYPASS_EN  = 1'b1,
    parameter int unsigned SELW       = 2
) (
    input  hazard_entry_t    entries [NSTAGES],
    input  reg_addr_t        src,
    input  logic             oen,
    output logic             stall,
    output logic [SELW-1:0]  byp_sel
);

    logic found;
    logic ready;
    logic unused_csr;

    // Lowest index is youngest; the first hit shadows any older writer of the same register.
    always_comb begin
        stall   = 1'b0;
        byp_sel = '0;
        found   = 1'b0;
        ready   = 1'b0;
        for (int unsigned k = 0; k < NSTAGES; k++) begin
            if (!found && oen && (src != '0) && entries[k].valid && entries[k].rf_wen &&
                (entries[k].wbaddr == src)) begin
                found = 1'b1;
                ready = !entries[k].is_load || (k >= LOAD_READY);
                if (ready && BYPASS_EN) begin
                    byp_sel = SELW'(k + 1);
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

    always_comb begin
        unused_csr = 1'b0;
        for (int unsigned k = 0; k < NSTAGES; k++) begin
            unused_csr = unused_csr ^ entries[k].is_csr;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard/bypass unit: shadow pipeline of in-flight writebacks plus stall/bypass decisions.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned CSR_DRAIN  = 1,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    localparam int unsigned SELW = sel_width(NSTAGES);

    hazard_entry_t    stage_q [NSTAGES];
    hazard_entry_t    issue_entry;
    logic             rs1_stall;
    logic             rs2_stall;
    logic             csr_hold;
    logic             busy;
    logic             stall;
    logic [SELW-1:0]  rs1_sel;
    logic [SELW-1:0]  rs2_sel;

    hazard_scoreboard_match #(
        .NSTAGES(NSTAGES), .LOAD_READY(LOAD_READY), .BYPASS_EN(BYPASS_EN), .SELW(SELW)
    ) u_match_rs1 (
        .entries(stage_q), .src(bus.dec_rs1_addr), .oen(bus.dec_rs1_oen),
        .stall(rs1_stall), .byp_sel(rs1_sel)
    );

    hazard_scoreboard_match #(
        .NSTAGES(NSTAGES), .LOAD_READY(LOAD_READY), .BYPASS_EN(BYPASS_EN), .SELW(SELW)
    ) u_match_rs2 (
        .entries(stage_q), .src(bus.dec_rs2_addr), .oen(bus.dec_rs2_oen),
        .stall(rs2_stall), .byp_sel(rs2_sel)
    );

    // CSR drain window and pipeline occupancy summaries.
    always_comb begin
        csr_hold = 1'b0;
        busy     = 1'b0;
        for (int unsigned k = 0; k < NSTAGES; k++) begin
            if ((k < CSR_DRAIN) && stage_q[k].valid && stage_q[k].is_csr) begin
                csr_hold = 1'b1;
            end
            if (stage_q[k].valid && (stage_q[k].rf_wen || stage_q[k].is_csr)) begin
                busy = 1'b1;
            end
        end
    end

    assign stall = bus.dec_valid && !bus.dec_kill && (rs1_stall || rs2_stall || csr_hold);

    assign bus.dec_stall   = stall;
    assign bus.rs1_byp_sel = rs1_sel;
    assign bus.rs2_byp_sel = rs2_sel;
    assign bus.pipe_busy   = busy;

    always_comb begin
        issue_entry         = '0;
        issue_entry.valid   = bus.dec_valid;
        issue_entry.wbaddr  = bus.dec_wb_addr;
        issue_entry.rf_wen  = bus.dec_rf_wen;
        issue_entry.is_load = bus.dec_is_load;
        issue_entry.is_csr  = bus.dec_is_csr;
    end

    // Shift register advance: reset clears, cache miss freezes, stall/kill inject a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NSTAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!bus.cmiss_stall) begin
            for (int unsigned k = 1; k < NSTAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
            stage_q[0] <= (stall || bus.dec_kill) ? hazard_entry_t'('0) : issue_entry;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: bypassing instance plus a full-interlock instance.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic      dec_valid, dec_rs1_oen, dec_rs2_oen, dec_rf_wen, dec_is_load, dec_is_csr;
    logic      dec_kill, cmiss_stall;
    reg_addr_t dec_rs1_addr, dec_rs2_addr, dec_wb_addr;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.SELW(2)) bus ();
    hazard_scoreboard_if #(.SELW(2)) bus_nb ();

    assign bus.dec_valid    = dec_valid;    assign bus_nb.dec_valid    = dec_valid;
    assign bus.dec_rs1_addr = dec_rs1_addr; assign bus_nb.dec_rs1_addr = dec_rs1_addr;
    assign bus.dec_rs2_addr = dec_rs2_addr; assign bus_nb.dec_rs2_addr = dec_rs2_addr;
    assign bus.dec_rs1_oen  = dec_rs1_oen;  assign bus_nb.dec_rs1_oen  = dec_rs1_oen;
    assign bus.dec_rs2_oen  = dec_rs2_oen;  assign bus_nb.dec_rs2_oen  = dec_rs2_oen;
    assign bus.dec_wb_addr  = dec_wb_addr;  assign bus_nb.dec_wb_addr  = dec_wb_addr;
    assign bus.dec_rf_wen   = dec_rf_wen;   assign bus_nb.dec_rf_wen   = dec_rf_wen;
    assign bus.dec_is_load  = dec_is_load;  assign bus_nb.dec_is_load  = dec_is_load;
    assign bus.dec_is_csr   = dec_is_csr;   assign bus_nb.dec_is_csr   = dec_is_csr;
    assign bus.dec_kill     = dec_kill;     assign bus_nb.dec_kill     = dec_kill;
    assign bus.cmiss_stall  = cmiss_stall;  assign bus_nb.cmiss_stall  = cmiss_stall;

    hazard_scoreboard #(.NSTAGES(3), .LOAD_READY(1), .CSR_DRAIN(1), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    hazard_scoreboard #(.NSTAGES(3), .LOAD_READY(1), .CSR_DRAIN(1), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .bus(bus_nb)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are sampled 2 time units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input int rs1, input logic o1, input int rs2,
                           input logic o2, input int wb, input logic wen, input logic ld,
                           input logic csr, input logic kill);
        dec_valid    = v;
        dec_rs1_addr = reg_addr_t'(rs1);
        dec_rs1_oen  = o1;
        dec_rs2_addr = reg_addr_t'(rs2);
        dec_rs2_oen  = o2;
        dec_wb_addr  = reg_addr_t'(wb);
        dec_rf_wen   = wen;
        dec_is_load  = ld;
        dec_is_csr   = csr;
        dec_kill     = kill;
        #2;
    endtask

    task automatic idle();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
        end
    endtask

    initial begin
        reset       = 1'b1;
        cmiss_stall = 1'b0;
        idle();
        tick();
        tick();
        check("reset_stall", 8'(bus.dec_stall), 8'd0);
        check("reset_sel1", 8'(bus.rs1_byp_sel), 8'd0);
        check("reset_busy", 8'(bus.pipe_busy), 8'd0);
        reset = 1'b0;

        // ADD x5 followed by consumers of x5: select walks 1,2,3 then regfile.
        tick();
        set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        check("t1_issue_stall", 8'(bus.dec_stall), 8'd0);
        tick();
        set_dec(1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
        check("t1_stall", 8'(bus.dec_stall), 8'd0);
        check("t1_sel1_1", 8'(bus.rs1_byp_sel), 8'd1);
        check("t1_sel2_x0", 8'(bus.rs2_byp_sel), 8'd0);
        check("t1_busy", 8'(bus.pipe_busy), 8'd1);
        tick();
        set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("t1_sel1_2", 8'(bus.rs1_byp_sel), 8'd2);
        tick();
        set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("t1_sel1_3", 8'(bus.rs1_byp_sel), 8'd3);
        tick();
        set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("t1_sel1_0", 8'(bus.rs1_byp_sel), 8'd0);
        flush();

        // Load-use: one stall cycle, then forward from stage 1 on both operands.
        set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        set_dec(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        check("t2_stall", 8'(bus.dec_stall), 8'd1);
        check("t2_sel1_stall", 8'(bus.rs1_byp_sel), 8'd0);
        tick();
        set_dec(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        check("t2_release", 8'(bus.dec_stall), 8'd0);
        check("t2_sel1", 8'(bus.rs1_byp_sel), 8'd2);
        check("t2_sel2", 8'(bus.rs2_byp_sel), 8'd2);
        flush();

        // Load to x0 never hazards; CSR op holds the next decode exactly one cycle.
        set_dec(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        set_dec(1, 0, 1, 0, 0, 7, 1, 0, 0, 0);
        check("t3_x0_stall", 8'(bus.dec_stall), 8'd0);
        check("t3_x0_sel", 8'(bus.rs1_byp_sel), 8'd0);
        tick();
        set_dec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("t3_csr_issue", 8'(bus.dec_stall), 8'd0);
        tick();
        set_dec(1, 9, 1, 0, 0, 8, 1, 0, 0, 0);
        check("t3_csr_stall", 8'(bus.dec_stall), 8'd1);
        check("t3_csr_busy", 8'(bus.pipe_busy), 8'd1);
        tick();
        set_dec(1, 9, 1, 0, 0, 8, 1, 0, 0, 0);
        check("t3_csr_release", 8'(bus.dec_stall), 8'd0);
        flush();

        // Cache miss freezes the load in stage 0; stall lifts one cycle after the miss clears.
        set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check("t4_stall0", 8'(bus.dec_stall), 8'd1);
        cmiss_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
            check("t4_frozen", 8'(bus.dec_stall), 8'd1);
        end
        cmiss_stall = 1'b0;
        #1;
        check("t4_drop", 8'(bus.dec_stall), 8'd1);
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check("t4_release", 8'(bus.dec_stall), 8'd0);
        check("t4_sel1", 8'(bus.rs1_byp_sel), 8'd2);
        flush();

        // Killed decode leaves a bubble; a killed dependent never stalls.
        set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
        check("t5_kill_stall", 8'(bus.dec_stall), 8'd0);
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check("t5_sel1", 8'(bus.rs1_byp_sel), 8'd0);
        check("t5_busy", 8'(bus.pipe_busy), 8'd0);
        check("t5_stall", 8'(bus.dec_stall), 8'd0);
        flush();
        set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
        check("t5_kill_hazard", 8'(bus.dec_stall), 8'd0);
        flush();

        // Full interlock: dependent waits until the writer leaves the pipe, no forwarding.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        check("t6_issue", 8'(bus_nb.dec_stall), 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
            check("t6_stall", 8'(bus_nb.dec_stall), 8'd1);
            check("t6_sel_stall", 8'(bus_nb.rs1_byp_sel), 8'd0);
        end
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check("t6_release", 8'(bus_nb.dec_stall), 8'd0);
        check("t6_sel", 8'(bus_nb.rs1_byp_sel), 8'd0);
        flush();
        set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check("t6_pre_reset", 8'(bus_nb.dec_stall), 8'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_reset_clear", 8'(bus_nb.dec_stall), 8'd0);
        check("t6_reset_busy", 8'(bus_nb.pipe_busy), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
